// File: rtl/irq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_sched_ctrl
// Description : Bus-mapped interrupt controller. It synchronises, latches,
//               masks and prioritises peripheral requests, then serialises
//               their service through a claim/EOI handshake driving CP0 HWInt.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sched_ctrl #(
    parameter int          NSRC = 6,
    parameter logic [31:0] BASE = 32'h7f30
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic [31:0]     addr,
    input  logic [3:0]      byteen,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [5:0]      hw_int
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PENDING   = 2'd1,
        ST_INSERVICE = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      cur_id;
    logic [NSRC-1:0] sync1, sync2, sync3;
    logic [NSRC-1:0] pend, mask, mode;

    logic            in_window;
    logic            wr_hit, wr_pend, wr_mask, wr_mode, wr_ctrl;
    logic            claim, eoi;
    logic [NSRC-1:0] pm, rise, clr, claim_clr;
    logic [4:0]      first_id;
    logic [5:0]      pm6;
    logic            unused_bits;

    assign in_window = (addr[31:4] == BASE[31:4]);
    assign wr_hit    = in_window && (byteen == 4'b1111);
    assign wr_pend   = wr_hit && (addr[3:2] == 2'd0);
    assign wr_mask   = wr_hit && (addr[3:2] == 2'd1);
    assign wr_mode   = wr_hit && (addr[3:2] == 2'd2);
    assign wr_ctrl   = wr_hit && (addr[3:2] == 2'd3);

    assign pm    = pend & mask;
    assign rise  = sync2 & ~sync3;
    // A claim that races with the last request vanishing is dropped; the FSM leaves PENDING instead.
    assign claim = wr_ctrl && !wdata[31] && (state == ST_PENDING) && (|pm);
    assign eoi   = wr_ctrl && wdata[31] && (state == ST_INSERVICE) && (wdata[4:0] == cur_id);
    assign clr   = (wr_pend ? wdata[NSRC-1:0] : '0) | claim_clr;

    assign unused_bits = ^{addr[1:0], wdata};

    // Fixed priority: lowest-numbered active source wins; also builds the claim clear vector.
    always_comb begin
        first_id  = 5'h1f;
        claim_clr = '0;
        pm6       = '0;
        pm6[NSRC-1:0] = pm;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pm[i]) first_id = 5'(i);
        end
        for (int i = 0; i < NSRC; i++) begin
            claim_clr[i] = claim && mode[i] && (first_id == 5'(i));
        end
    end

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= src_irq;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Pending/mask/mode registers; edge bits are sticky with set beating clear, level bits track input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            mask <= '0;
            mode <= '0;
        end else begin
            pend <= (mode & ((pend & ~clr) | rise)) | (~mode & sync2);
            if (wr_mask) mask <= wdata[NSRC-1:0];
            if (wr_mode) mode <= wdata[NSRC-1:0];
        end
    end

    // Service FSM with registered HWInt vector and claimed source id.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cur_id <= 5'h1f;
            hw_int <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pm) begin
                        state  <= ST_PENDING;
                        hw_int <= pm6;
                    end else begin
                        hw_int <= '0;
                    end
                end
                ST_PENDING: begin
                    if (!(|pm)) begin
                        state  <= ST_IDLE;
                        hw_int <= '0;
                    end else if (claim) begin
                        state  <= ST_INSERVICE;
                        cur_id <= first_id;
                        hw_int <= '0;
                    end else begin
                        hw_int <= pm6;
                    end
                end
                ST_INSERVICE: begin
                    hw_int <= '0;
                    if (eoi) begin
                        state  <= ST_IDLE;
                        cur_id <= 5'h1f;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cur_id <= 5'h1f;
                    hw_int <= '0;
                end
            endcase
        end
    end

    // Combinational register read-back; zero outside the window.
    always_comb begin
        rdata = '0;
        if (in_window) begin
            case (addr[3:2])
                2'd0: rdata[NSRC-1:0] = pend;
                2'd1: rdata[NSRC-1:0] = mask;
                2'd2: rdata[NSRC-1:0] = mode;
                default: begin
                    rdata[31]  = (state == ST_INSERVICE);
                    rdata[4:0] = cur_id;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sched_ctrl
// Description : Self-checking bench for irq_sched_ctrl (step table plus
//               hand-written multi-cycle sequences, queue-based scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sched_ctrl;

    localparam logic [31:0] BASE = 32'h7f30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  src_irq = '0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [5:0]  hw_int;

    int errors = 0;
    int checks = 0;

    irq_sched_ctrl #(.NSRC(6), .BASE(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .addr    (addr),
        .byteen  (byteen),
        .wdata   (wdata),
        .rdata   (rdata),
        .hw_int  (hw_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [5:0]  src;
        bit          do_wr;
        logic [3:0]  off;
        logic [31:0] wd;
        int          n;
        logic [5:0]  exp_hw;
        logic [3:0]  rd_off;
        logic [31:0] exp_rd;
    } step_t;
    step_t tbl[13];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] got);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h, no expected value queued", got);
        end else begin
            e = sbq.pop_front();
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
        addr   = BASE | {28'b0, off};
        wdata  = d;
        byteen = be;
        cyc();
        byteen = 4'b0000;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] v);
        addr   = BASE | {28'b0, off};
        byteen = 4'b0000;
        #1;
        v = rdata;
    endtask

    task automatic chk_rd(input string n, input logic [3:0] off, input logic [31:0] e);
        logic [31:0] v;
        push_exp(n, e);
        rd(off, v);
        pop_cmp(v);
    endtask

    task automatic chk_hw(input string n, input logic [5:0] e);
        push_exp(n, {26'b0, e});
        pop_cmp({26'b0, hw_int});
    endtask

    task automatic pulse(input logic [5:0] m);
        src_irq = src_irq | m;
        cyc();
        src_irq = src_irq & ~m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;

        //          src    wr  off    wdata          n  hw     rd     exp_rd
        tbl[0]  = '{6'h00, 1, 4'h8, 32'h0000_0001, 0, 6'h00, 4'h8, 32'h0000_0001};
        tbl[1]  = '{6'h00, 1, 4'h4, 32'h0000_0001, 0, 6'h00, 4'h4, 32'h0000_0001};
        tbl[2]  = '{6'h01, 0, 4'h0, 32'h0,         0, 6'h00, 4'h0, 32'h0000_0000};
        tbl[3]  = '{6'h00, 0, 4'h0, 32'h0,         1, 6'h00, 4'h0, 32'h0000_0001};
        tbl[4]  = '{6'h00, 0, 4'h0, 32'h0,         0, 6'h01, 4'hc, 32'h0000_001f};
        tbl[5]  = '{6'h00, 1, 4'hc, 32'h0000_0000, 0, 6'h00, 4'hc, 32'h8000_0000};
        tbl[6]  = '{6'h00, 1, 4'hc, 32'h8000_0000, 0, 6'h00, 4'hc, 32'h0000_001f};
        tbl[7]  = '{6'h00, 0, 4'h0, 32'h0,         2, 6'h00, 4'h0, 32'h0000_0000};
        tbl[8]  = '{6'h0a, 1, 4'h4, 32'h0000_000a, 3, 6'h0a, 4'h0, 32'h0000_000a};
        tbl[9]  = '{6'h0a, 1, 4'hc, 32'h0000_0000, 0, 6'h00, 4'hc, 32'h8000_0001};
        tbl[10] = '{6'h0a, 1, 4'hc, 32'h8000_0001, 0, 6'h00, 4'hc, 32'h0000_001f};
        tbl[11] = '{6'h0a, 0, 4'h0, 32'h0,         0, 6'h0a, 4'h0, 32'h0000_000a};
        tbl[12] = '{6'h00, 1, 4'h4, 32'h0000_0000, 3, 6'h00, 4'h0, 32'h0000_0000};

        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;

        // Reset state
        chk_hw("reset_hw", 6'h00);
        chk_rd("reset_pend", 4'h0, 32'h0);
        chk_rd("reset_mask", 4'h4, 32'h0);
        chk_rd("reset_mode", 4'h8, 32'h0);
        chk_rd("reset_ctrl", 4'hc, 32'h0000_001f);
        push_exp("outside_window", 32'h0);
        addr = 32'h0000_7f40;
        #1;
        pop_cmp(rdata);

        // Edge source 0 end to end, then level sources 1 and 3
        for (int i = 0; i < 13; i++) begin
            push_exp($sformatf("step%0d_hw", i), {26'b0, tbl[i].exp_hw});
            push_exp($sformatf("step%0d_rd", i), tbl[i].exp_rd);
            src_irq = tbl[i].src;
            if (tbl[i].do_wr) wr(tbl[i].off, tbl[i].wd, 4'b1111);
            else cyc();
            for (int k = 0; k < tbl[i].n; k++) cyc();
            pop_cmp({26'b0, hw_int});
            rd(tbl[i].rd_off, v);
            pop_cmp(v);
        end

        // Edge src2 arriving while src0 is in service is held off until EOI
        wr(4'h8, 32'h05, 4'b1111);
        wr(4'h4, 32'h05, 4'b1111);
        pulse(6'h01);
        repeat (3) cyc();
        chk_hw("s3_hw_src0", 6'h01);
        wr(4'hc, 32'h0, 4'b1111);
        chk_rd("s3_ctrl_claim0", 4'hc, 32'h8000_0000);
        pulse(6'h04);
        repeat (4) cyc();
        chk_hw("s3_hw_held", 6'h00);
        chk_rd("s3_pend2", 4'h0, 32'h0000_0004);
        wr(4'hc, 32'h8000_0000, 4'b1111);
        chk_hw("s3_hw_after_eoi", 6'h00);
        cyc();
        chk_hw("s3_hw_reentry", 6'h04);

        // Wrong-id EOI and partial store are both ignored
        wr(4'hc, 32'h0, 4'b1111);
        chk_rd("s4_ctrl_claim2", 4'hc, 32'h8000_0002);
        wr(4'hc, 32'h8000_0004, 4'b1111);
        chk_rd("s4_wrong_id", 4'hc, 32'h8000_0002);
        wr(4'hc, 32'h8000_0002, 4'b0011);
        chk_rd("s4_partial", 4'hc, 32'h8000_0002);
        chk_hw("s4_hw", 6'h00);
        wr(4'hc, 32'h8000_0002, 4'b1111);
        chk_rd("s4_eoi_ok", 4'hc, 32'h0000_001f);

        // W1C colliding with a fresh edge: set wins; lone W1C clears
        pulse(6'h04);
        cyc();
        wr(4'h0, 32'h04, 4'b1111);
        chk_rd("s5_set_wins", 4'h0, 32'h0000_0004);
        wr(4'h0, 32'h04, 4'b1111);
        chk_rd("s5_w1c", 4'h0, 32'h0000_0000);
        cyc();
        chk_hw("s5_hw", 6'h00);

        // Reset in the middle of a service
        pulse(6'h01);
        repeat (3) cyc();
        wr(4'hc, 32'h0, 4'b1111);
        chk_rd("s6_ctrl_insvc", 4'hc, 32'h8000_0000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_hw("s6_hw", 6'h00);
        chk_rd("s6_mask", 4'h4, 32'h0);
        chk_rd("s6_mode", 4'h8, 32'h0);
        chk_rd("s6_ctrl", 4'hc, 32'h0000_001f);
        cyc();
        chk_rd("s6_ctrl_idle", 4'hc, 32'h0000_001f);
        chk_hw("s6_hw_idle", 6'h00);

        if (sbq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
